// File: rtl/ir_tx.sv
// NEC-format IR transmitter: lead code, 32 pulse-distance bits MSB first, stop mark, idle gap.
// Drives the envelope in both polarities plus a carrier-gated LED output.
module ir_tx #(
   parameter int unsigned CLK_DIV      = 50,
   parameter int unsigned CARRIER_DIV  = 1316,
   parameter int unsigned T_LEAD_MARK  = 9000,
   parameter int unsigned T_LEAD_SPACE = 4500,
   parameter int unsigned T_BIT_MARK   = 560,
   parameter int unsigned T_ZERO_SPACE = 560,
   parameter int unsigned T_ONE_SPACE  = 1690,
   parameter int unsigned T_GAP        = 40000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [31:0] i_data,
   output logic        o_ir_tx,
   output logic        o_ir_txb,
   output logic        o_ir_mod,
   output logic        o_busy,
   output logic        o_done
);

   localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

   typedef enum logic [2:0] {
      StIdle, StLeadMark, StLeadSpace, StBitMark, StBitSpace, StStopMark, StGap
   } state_e;

   state_e        r_state, w_state_d;
   logic [TW-1:0] r_tick, w_tick_d;
   logic [15:0]   r_dur, w_dur_d, w_dur_len;
   logic [4:0]    r_bit_idx, w_bit_idx_d;
   logic [31:0]   r_data, w_data_d;
   logic [CW-1:0] r_car, w_car_d;
   logic          r_ir_tx, r_busy, r_done;
   logic          w_ir_tx_d, w_busy_d, w_done_d;
   logic          w_tick, w_seg_end;

   always_comb begin
      w_dur_len = 16'd1;
      case (r_state)
         StLeadMark:             w_dur_len = 16'(T_LEAD_MARK);
         StLeadSpace:            w_dur_len = 16'(T_LEAD_SPACE);
         StBitMark, StStopMark:  w_dur_len = 16'(T_BIT_MARK);
         StBitSpace:             w_dur_len = r_data[r_bit_idx] ? 16'(T_ONE_SPACE)
                                                               : 16'(T_ZERO_SPACE);
         StGap:                  w_dur_len = 16'(T_GAP);
         default:                w_dur_len = 16'd1;
      endcase
   end

   assign w_tick    = (r_tick == TW'(CLK_DIV - 1));
   assign w_seg_end = w_tick && (r_dur == w_dur_len - 16'd1);

   always_comb begin
      w_state_d   = r_state;
      w_tick_d    = w_tick ? '0 : r_tick + TW'(1);
      w_dur_d     = w_tick ? r_dur + 16'd1 : r_dur;
      w_bit_idx_d = r_bit_idx;
      w_data_d    = r_data;
      w_done_d    = 1'b0;
      case (r_state)
         StIdle: begin
            // Hold the tick phase at zero so the first segment is exactly full length
            w_tick_d = '0;
            w_dur_d  = '0;
            if (i_start) begin
               w_state_d   = StLeadMark;
               w_data_d    = i_data;
               w_bit_idx_d = 5'd31;
            end
         end
         StLeadMark:  if (w_seg_end) w_state_d = StLeadSpace;
         StLeadSpace: if (w_seg_end) w_state_d = StBitMark;
         StBitMark:   if (w_seg_end) w_state_d = StBitSpace;
         StBitSpace: begin
            if (w_seg_end) begin
               if (r_bit_idx == 5'd0) begin
                  w_state_d = StStopMark;
               end else begin
                  w_bit_idx_d = r_bit_idx - 5'd1;
                  w_state_d   = StBitMark;
               end
            end
         end
         StStopMark:  if (w_seg_end) w_state_d = StGap;
         StGap: begin
            if (w_seg_end) begin
               w_state_d = StIdle;
               w_done_d  = 1'b1;
            end
         end
         default:     w_state_d = StIdle;
      endcase
      if (w_state_d != r_state) w_dur_d = '0;

      w_ir_tx_d = (w_state_d == StLeadMark) || (w_state_d == StBitMark) ||
                  (w_state_d == StStopMark);
      w_busy_d  = (w_state_d != StIdle);

      w_car_d = (r_car == CW'(CARRIER_DIV - 1)) ? '0 : r_car + CW'(1);
      // Carrier phase restarts at every mark entry and rests at zero in spaces
      if (!w_ir_tx_d || (w_state_d != r_state)) w_car_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_tick    <= '0;
         r_dur     <= '0;
         r_bit_idx <= '0;
         r_data    <= '0;
         r_car     <= '0;
         r_ir_tx   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_tick    <= w_tick_d;
         r_dur     <= w_dur_d;
         r_bit_idx <= w_bit_idx_d;
         r_data    <= w_data_d;
         r_car     <= w_car_d;
         r_ir_tx   <= w_ir_tx_d;
         r_busy    <= w_busy_d;
         r_done    <= w_done_d;
      end
   end

   assign o_ir_tx  = r_ir_tx;
   assign o_ir_txb = ~r_ir_tx;
   assign o_ir_mod = r_ir_tx & (r_car < CW'(CARRIER_DIV / 2));
   assign o_busy   = r_busy;
   assign o_done   = r_done;

endmodule

// File: tb/tb_ir_tx.sv
// Bench for ir_tx with shrunk timing: random frames checked cycle by cycle against a segment
// list built from the NEC rules, plus a run-length decoder acting as the receiving end.
module tb_ir_tx;

   localparam int unsigned CD  = 2;
   localparam int unsigned CAR = 6;
   localparam int unsigned LM  = 16;
   localparam int unsigned LS  = 8;
   localparam int unsigned BM  = 2;
   localparam int unsigned ZS  = 2;
   localparam int unsigned OS  = 5;
   localparam int unsigned GP  = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [31:0] i_data = '0;
   logic        o_ir_tx, o_ir_txb, o_ir_mod, o_busy, o_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ir_tx #(
      .CLK_DIV      (CD),
      .CARRIER_DIV  (CAR),
      .T_LEAD_MARK  (LM),
      .T_LEAD_SPACE (LS),
      .T_BIT_MARK   (BM),
      .T_ZERO_SPACE (ZS),
      .T_ONE_SPACE  (OS),
      .T_GAP        (GP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (i_start),
      .i_data   (i_data),
      .o_ir_tx  (o_ir_tx),
      .o_ir_txb (o_ir_txb),
      .o_ir_mod (o_ir_mod),
      .o_busy   (o_busy),
      .o_done   (o_done)
   );

   function automatic logic [4:0] outs();
      return {o_ir_tx, o_ir_txb, o_ir_mod, o_busy, o_done};
   endfunction

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (outs() !== 5'b01000) begin
         bad++;
         $display("FAIL reset_hold got=%b exp=%b", outs(), 5'b01000);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (outs() !== 5'b01000) begin
         bad++;
         $display("FAIL reset_idle got=%b exp=%b", outs(), 5'b01000);
      end
   endtask

   // inject_at: cycle at which a second start is offered (-1 none, -2 on the last GAP cycle)
   // reset_at : cycle after which rst_n is pulsed (-1 none); the task returns right after
   task automatic test_frame(input logic [31:0] data, input int inject_at,
                             input logic [31:0] inject_data, input int reset_at,
                             input string name);
      int lvl[$];
      int len[$];
      int frame_len = 0;
      int c = 0;
      int inj;
      logic [4:0] exp;
      lvl.push_back(1); len.push_back(LM * CD);
      lvl.push_back(0); len.push_back(LS * CD);
      for (int i = 31; i >= 0; i--) begin
         lvl.push_back(1); len.push_back(BM * CD);
         lvl.push_back(0); len.push_back((data[i] ? OS : ZS) * CD);
      end
      lvl.push_back(1); len.push_back(BM * CD);
      lvl.push_back(0); len.push_back(GP * CD);
      foreach (len[s]) frame_len += len[s];
      inj = (inject_at == -2) ? frame_len - 1 : inject_at;

      @(negedge clk);
      i_start = 1'b1;
      i_data  = data;
      foreach (len[s]) begin
         for (int k = 0; k < len[s]; k++) begin
            @(negedge clk);
            exp = {lvl[s] == 1, lvl[s] == 0, (lvl[s] == 1) && ((k % CAR) < CAR / 2),
                   1'b1, 1'b0};
            total++;
            if (outs() !== exp) begin
               bad++;
               $display("FAIL %s cyc=%0d got=%b exp=%b", name, c, outs(), exp);
            end
            if (c == reset_at) begin
               #2 rst_n = 1'b0;
               #1;
               total++;
               if (outs() !== 5'b01000) begin
                  bad++;
                  $display("FAIL %s_async_reset got=%b exp=%b", name, outs(), 5'b01000);
               end
               i_start = 1'b0;
               @(negedge clk);
               rst_n = 1'b1;
               @(negedge clk);
               return;
            end
            i_start = (c == inj);
            i_data  = (c == inj) ? inject_data : $urandom;
            c++;
         end
      end
      @(negedge clk);
      i_start = 1'b0;
      total++;
      if (outs() !== 5'b01001) begin
         bad++;
         $display("FAIL %s_done got=%b exp=%b", name, outs(), 5'b01001);
      end
      @(negedge clk);
      total++;
      if (outs() !== 5'b01000) begin
         bad++;
         $display("FAIL %s_after_done got=%b exp=%b", name, outs(), 5'b01000);
      end
   endtask

   // Receiver-side view: measure mark/space run lengths and recover the word
   task automatic test_decode(input logic [31:0] data, input string name);
      int runs[$];
      int cnt = 0;
      logic prev = 1'b1;
      logic finished = 1'b0;
      logic saw_done = 1'b0;
      logic [31:0] word = '0;
      @(negedge clk);
      i_start = 1'b1;
      i_data  = data;
      for (int n = 0; n < 5000 && !finished; n++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (!o_busy) begin
            runs.push_back(cnt);
            finished = 1'b1;
            saw_done = o_done;
         end else if (o_ir_tx == prev) begin
            cnt++;
         end else begin
            runs.push_back(cnt);
            prev = o_ir_tx;
            cnt = 1;
         end
      end
      total++;
      if (!finished || runs.size() != 68) begin
         bad++;
         $display("FAIL %s_runs finished=%0b got=%0d exp=68", name, finished, runs.size());
         return;
      end
      total++;
      if (runs[0] != LM * CD || runs[1] != LS * CD || runs[2] != BM * CD) begin
         bad++;
         $display("FAIL %s_lead got=%0d/%0d/%0d exp=%0d/%0d/%0d", name, runs[0], runs[1],
                  runs[2], LM * CD, LS * CD, BM * CD);
      end
      total++;
      if (runs[66] != BM * CD || runs[67] != GP * CD) begin
         bad++;
         $display("FAIL %s_stop_gap got=%0d/%0d exp=%0d/%0d", name, runs[66], runs[67],
                  BM * CD, GP * CD);
      end
      for (int j = 0; j < 32; j++) word[31 - j] = (runs[3 + 2 * j] > (ZS + OS) * CD / 2);
      total++;
      if (word !== data) begin
         bad++;
         $display("FAIL %s_word got=%h exp=%h", name, word, data);
      end
      total++;
      if (saw_done !== 1'b1) begin
         bad++;
         $display("FAIL %s_done_pulse got=%b exp=1", name, saw_done);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midframe(input logic [31:0] data);
      int at = (LM + LS) * CD;
      for (int i = 31; i > 10; i--) at += (BM + (data[i] ? OS : ZS)) * CD;
      at += BM * CD + 1;
      test_frame(data, -1, '0, at, "reset_mid");
      test_frame(~data, -1, '0, -1, "after_reset");
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      test_decode(32'hA5C3_0FF0, "loopback");
      test_frame(32'hA5C3_0FF0, -1, '0, -1, "fixed_frame");
      test_frame(32'h8000_0000, -1, '0, -1, "one_then_zeros");
      test_decode(32'h8000_0000, "decode_msb");
      test_frame(32'hDEAD_BEEF, 100, 32'h1234_5678, -1, "start_while_busy");
      test_frame(32'h0F0F_3C3C, -2, 32'h1234_5678, -1, "start_on_done");
      for (int r = 0; r < 3; r++) begin
         logic [31:0] w;
         w = $urandom;
         test_frame(w, $urandom_range(60, 300), $urandom, -1, "random_frame");
         test_decode(~w, "random_decode");
      end
      test_reset_midframe($urandom);
      test_frame(32'hFFFF_FFFF, -1, '0, -1, "all_ones");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
